// File: rtl/pu_fifo_pkg.sv
// Definitions shared by the processing units on the data/attribute bus:
// attribute bit positions and the stored bus word layout.
package pu_fifo_pkg;

  localparam int SIGN       = 0;
  localparam int OVERFLOW   = 1;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_ATTR_W = 4;

  typedef struct packed {
    logic [BUS_ATTR_W-1:0] attr;
    logic [BUS_DATA_W-1:0] data;
  } bus_word_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pu_fifo_mem.sv
// Register array holding the buffered bus words: one synchronous write port
// and one combinational read port so the head is available for the pop register.
module pu_fifo_mem
  import pu_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BUS_ATTR_W + BUS_DATA_W,
  localparam int AW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pu_fifo.sv
// Bus-side result buffer: captures accumulator results with their attributes
// and replays them in order when granted the bus; output is zero when idle.
module pu_fifo
  import pu_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int SIGN       = pu_fifo_pkg::SIGN,
  parameter int OVERFLOW   = pu_fifo_pkg::OVERFLOW,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic                  signal_init,
  input  logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int WORD_W = ATTR_WIDTH + DATA_WIDTH;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [ATTR_WIDTH-1:0] UNDERFLOW_ATTR =
    {{(ATTR_WIDTH - 1){1'b0}}, 1'b1} << OVERFLOW;

  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]        count_reg, count_next;
  logic                  sticky_reg, sticky_next;
  logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
  logic [ATTR_WIDTH-1:0] attr_out_reg, attr_out_next;

  logic [WORD_W-1:0]     head_word;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ATTR_WIDTH-1:0] head_attr;
  logic [ATTR_WIDTH-1:0] head_attr_flagged;
  logic                  full, empty, do_pop, do_push, do_drop;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign do_pop  = signal_oe && !empty;
  assign do_push = signal_wr && !signal_init && (!full || do_pop);
  assign do_drop = signal_wr && !signal_init && full && !do_pop;

  pu_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr_reg),
    .wdata ({attr_in, data_in}),
    .raddr (rd_ptr_reg),
    .rdata (head_word)
  );

  assign head_data = head_word[DATA_WIDTH-1:0];
  assign head_attr = head_word[WORD_W-1:DATA_WIDTH];

  // Only the overflow bit picks up a lost write; sign and the rest pass verbatim.
  for (genvar gi = 0; gi < ATTR_WIDTH; gi++) begin : g_attr
    if (gi == OVERFLOW && gi != SIGN) begin : g_ovf
      assign head_attr_flagged[gi] = head_attr[gi] | sticky_reg;
    end else begin : g_pass
      assign head_attr_flagged[gi] = head_attr[gi];
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    sticky_next = sticky_reg;
    if (signal_init) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      sticky_next = 1'b0;
    end else begin
      if (do_pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
        sticky_next = 1'b0;
      end
      if (do_push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (do_drop) begin
        sticky_next = 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // The output is computed from pre-flush state even when init is asserted.
  always_comb begin
    data_out_next = '0;
    attr_out_next = '0;
    if (signal_oe) begin
      if (!empty) begin
        data_out_next = head_data;
        attr_out_next = head_attr_flagged;
      end else begin
        attr_out_next = UNDERFLOW_ATTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      sticky_reg   <= 1'b0;
      data_out_reg <= '0;
      attr_out_reg <= '0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      sticky_reg   <= sticky_next;
      data_out_reg <= data_out_next;
      attr_out_reg <= attr_out_next;
    end
  end

  assign data_out = data_out_reg;
  assign attr_out = attr_out_reg;

endmodule

// File: tb/tb_pu_fifo.sv
// Scoreboard bench for pu_fifo: directed scenarios followed by random traffic,
// with expectations produced by a queue-based reference model.
module tb_pu_fifo;
  import pu_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signal_wr = 1'b0;
  logic        signal_init = 1'b0;
  logic        signal_oe = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  attr_in = '0;
  logic [31:0] data_out;
  logic [3:0]  attr_out;

  int total = 0;
  int bad   = 0;

  bus_word_t model_q[$];
  bit        model_sticky = 1'b0;
  bus_word_t exp_q[$];

  always #5 clk = ~clk;

  pu_fifo #(
    .DATA_WIDTH (32),
    .ATTR_WIDTH (4),
    .SIGN       (SIGN),
    .OVERFLOW   (OVERFLOW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .signal_wr   (signal_wr),
    .signal_init (signal_init),
    .signal_oe   (signal_oe),
    .data_in     (data_in),
    .attr_in     (attr_in),
    .data_out    (data_out),
    .attr_out    (attr_out)
  );

  // One bus cycle: drive inputs, predict the word the following edge produces.
  task automatic cycle(input bit wr, input bit oe, input bit init,
                       input logic [31:0] d, input logic [3:0] a);
    bus_word_t e;
    bus_word_t w;
    @(negedge clk);
    signal_wr   = wr;
    signal_oe   = oe;
    signal_init = init;
    data_in     = d;
    attr_in     = a;
    e = '0;
    if (oe) begin
      if (model_q.size() > 0) begin
        e = model_q[0];
        if (model_sticky) e.attr[OVERFLOW] = 1'b1;
      end else begin
        e.attr[OVERFLOW] = 1'b1;
      end
    end
    exp_q.push_back(e);
    if (init) begin
      model_q.delete();
      model_sticky = 1'b0;
    end else begin
      if (oe && model_q.size() > 0) begin
        void'(model_q.pop_front());
        model_sticky = 1'b0;
      end
      if (wr) begin
        if (model_q.size() < DEPTH) begin
          w.data = d;
          w.attr = a;
          model_q.push_back(w);
        end else begin
          model_sticky = 1'b1;
        end
      end
    end
  endtask

  task automatic check_now(input string name, input logic [31:0] want_d,
                           input logic [3:0] want_a);
    total++;
    if (data_out !== want_d || attr_out !== want_a) begin
      bad++;
      $display("FAIL %s got data=%h attr=%b want data=%h attr=%b",
               name, data_out, attr_out, want_d, want_a);
    end else begin
      $display("ok   %s data=%h attr=%b", name, data_out, attr_out);
    end
  endtask

  // Monitor: each edge the DUT presents one bus word; compare against the queue.
  initial begin
    bus_word_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (data_out !== e.data || attr_out !== e.attr) begin
          bad++;
          $display("FAIL scoreboard#%0d got data=%h attr=%b want data=%h attr=%b",
                   total, data_out, attr_out, e.data, e.attr);
        end else begin
          $display("ok   scoreboard#%0d data=%h attr=%b", total, data_out, attr_out);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_now("reset_state", 32'h0, 4'b0000);
    rst = 1'b1;

    // In-order replay of three results
    cycle(1, 0, 0, 32'h10, 4'b0000);
    cycle(1, 0, 0, 32'h20, 4'b0001);
    cycle(1, 0, 0, 32'h30, 4'b0010);
    cycle(0, 1, 0, 32'h0, 4'b0000);
    cycle(0, 1, 0, 32'h0, 4'b0000);
    cycle(0, 1, 0, 32'h0, 4'b0000);
    cycle(0, 0, 0, 32'h0, 4'b0000);

    // Overflow on a full FIFO is reported on the next popped word only
    for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 32'(i), 4'b0000);
    cycle(1, 0, 0, 32'h5, 4'b0000);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'h0, 4'b0000);

    // Underflow word, then idle
    cycle(0, 1, 0, 32'h0, 4'b0000);
    cycle(0, 0, 0, 32'h0, 4'b0000);

    // Push and pop together on a full FIFO
    for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 32'(i), 4'b0001);
    cycle(1, 1, 0, 32'h9, 4'b0001);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'h0, 4'b0000);
    cycle(1, 1, 0, 32'h44, 4'b1011);
    cycle(0, 1, 0, 32'h0, 4'b0000);

    // Flush with simultaneous pop
    cycle(1, 0, 0, 32'h7, 4'b0000);
    cycle(1, 0, 0, 32'h8, 4'b0000);
    cycle(1, 1, 1, 32'h99, 4'b0000);
    cycle(0, 1, 0, 32'h0, 4'b0000);

    // Asynchronous reset while a word is on the bus
    cycle(1, 0, 0, 32'h10, 4'b0000);
    cycle(1, 0, 0, 32'h20, 4'b0000);
    cycle(0, 1, 0, 32'h0, 4'b0000);
    cycle(0, 1, 0, 32'h0, 4'b0000);
    @(posedge clk);
    #2;
    check_now("before_async_reset", 32'h20, 4'b0000);
    signal_oe = 1'b0;
    signal_wr = 1'b0;
    rst = 1'b0;
    #1;
    check_now("async_reset_output", 32'h0, 4'b0000);
    model_q.delete();
    model_sticky = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 1, 0, 32'h0, 4'b0000);
    cycle(0, 0, 0, 32'h0, 4'b0000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3, $urandom, 4'($urandom_range(0, 15)));
    end
    cycle(0, 0, 0, 32'h0, 4'b0000);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
